// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// byte-enable and store-lane replication functions.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    // funct3[1:0] carries the access size for both signed and unsigned forms.
    function automatic logic [3:0] byte_enable(logic [2:0] funct3, logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(logic [2:0] funct3, logic [31:0] data);
        case (funct3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-aligned request/grant/rvalid data-memory bus between the LSU (master) and
// memory (slave).
interface lsu_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and
// extension, plus detection of illegal funct3 and misaligned addresses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic        legal;
    logic        misaligned;
    logic [31:0] shifted;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !write;
            default:          legal = 1'b0;
        endcase

        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        err        = !legal || misaligned;

        be        = byte_enable(funct3, addr_lo);
        wdata_rep = replicate(funct3, wdata);

        // Bring the addressed lane down to bit 0 before extending.
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata_ext = {24'h000000, shifted[7:0]};
            F3_HU:   rdata_ext = {16'h0000, shifted[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, runs it on the data-memory bus
// and returns an extended load result or an error with a one-cycle rsp_valid pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    lsu_if.master                 mem
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("load_store_unit: only DATA_WIDTH == 32 is supported");
    end

    lsu_state_t            state_q, state_d;
    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [3:0]            mem_be_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic        idle, accept;
    logic        a_write, a_err;
    logic [2:0]  a_funct3;
    logic [1:0]  a_addr_lo;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;

    assign idle   = (state_q == IDLE);
    assign accept = idle && req_valid;

    // While idle the aligner decodes the incoming request; afterwards the latched one.
    assign a_write   = idle ? req_write      : write_q;
    assign a_funct3  = idle ? req_funct3     : funct3_q;
    assign a_addr_lo = idle ? req_addr[1:0]  : addr_lo_q;

    lsu_align u_align (
        .write     (a_write),
        .funct3    (a_funct3),
        .addr_lo   (a_addr_lo),
        .wdata     (req_wdata),
        .rdata     (mem.mem_rdata),
        .be        (a_be),
        .wdata_rep (a_wdata),
        .rdata_ext (a_rdata),
        .err       (a_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = a_err ? DONE : REQ;
            REQ:     if (mem.mem_gnt) state_d = write_q ? DONE : WAIT;
            WAIT:    if (mem.mem_rvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q   <= req_write;
                funct3_q  <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                if (a_err) begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b1;
                end else begin
                    mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be_q    <= a_be;
                    mem_wdata_q <= a_wdata;
                end
            end
            if ((state_q == REQ) && mem.mem_gnt && write_q) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b0;
            end
            if ((state_q == WAIT) && mem.mem_rvalid) begin
                rsp_rdata_q <= a_rdata;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready     = idle;
    assign busy          = !idle;
    assign rsp_valid     = (state_q == DONE);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = write_q && (state_q == REQ);
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

    // Stray bus responses are dropped by the FSM; flag them for visibility only.
    a_gnt_in_req: assert property (@(posedge clk) disable iff (!rst_n)
        mem.mem_gnt |-> (state_q == REQ))
        else $warning("load_store_unit: stray mem_gnt outside REQ ignored");
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        mem.mem_rvalid |-> (state_q == WAIT))
        else $warning("load_store_unit: stray mem_rvalid outside WAIT ignored");

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// scored against a byte-lane reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          lat;
        logic        saw_req;
        logic        stable;
        logic        timed_out;
        logic        we;
        logic        err;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } obs_t;

    lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem        (mem_bus.master)
    );

    always #5 clk = ~clk;

    // Reference: size from funct3, lanes by plain byte arithmetic.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic err, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] rd);
        int size, off;
        logic legal;
        logic [31:0] mask, v;
        off = int'(addr[1:0]);
        legal = 1'b1;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default: begin size = 4; legal = 1'b0; end
        endcase
        if (w && f3[2]) legal = 1'b0;
        err = !legal || ((off % size) != 0);
        be = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v = (rdata >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        rd = (w || err) ? 32'h0 : v;
    endfunction

    // Drives one access starting just after a rising edge with the DUT idle.
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly, output obs_t o);
        int req_cycles, gnt_cycle;
        logic granted;
        o = '{lat: 0, saw_req: 1'b0, stable: 1'b1, timed_out: 1'b1, we: 1'b0, err: 1'b0,
              be: 4'h0, addr: 32'h0, wdata: 32'h0, rd: 32'h0};
        granted = 1'b0; req_cycles = 0; gnt_cycle = 0;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 64; c++) begin
            mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = $urandom;
            if (mem_bus.mem_req && !granted) begin
                if (!o.saw_req) begin
                    o.saw_req = 1'b1; o.be = mem_bus.mem_be; o.addr = mem_bus.mem_addr;
                    o.wdata = mem_bus.mem_wdata; o.we = mem_bus.mem_we;
                end else if ({mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata,
                              mem_bus.mem_we} !== {o.be, o.addr, o.wdata, o.we}) begin
                    o.stable = 1'b0;
                end
                if (busy !== 1'b1 || req_ready !== 1'b0) o.stable = 1'b0;
                if (req_cycles == gnt_dly) begin
                    mem_bus.mem_gnt = 1'b1; granted = 1'b1; gnt_cycle = c;
                end
                req_cycles++;
            end
            if (granted && !o.we && c == gnt_cycle + 1 + rv_dly) begin
                mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rdata;
            end
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                o.lat = c; o.rd = rsp_rdata; o.err = rsp_err; o.timed_out = 1'b0;
            end
            @(posedge clk); #1;
            if (!o.timed_out) break;
        end
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, busy, rsp_valid, rsp_err, mem_bus.mem_req, mem_bus.mem_we} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 100000", {req_ready, busy, rsp_valid, rsp_err,
                     mem_bus.mem_req, mem_bus.mem_we});
        end
        n_tests++;
        if ({rsp_rdata, mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata} !== 100'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata %h addr %h be %b wdata %h want all 0", rsp_rdata,
                     mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_basic();
        obs_t o;
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, o);
        n_tests++;
        if (o.timed_out || o.lat != 3 || o.rd !== 32'hDEAD_BEEF || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_basic: lat %0d rd %h err %b want lat 3 rd deadbeef err 0",
                     o.lat, o.rd, o.err);
        end
        n_tests++;
        if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.we !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_bus: addr %h be %b we %b want 100 1111 0", o.addr, o.be, o.we);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, f3s[i], adr[i], 32'h0, 32'h80FF_FF7F, 0, 0, o);
            n_tests++;
            if (o.timed_out || o.rd !== exp[i] || o.err !== 1'b0 || o.addr !== 32'h100) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: rd %h err %b addr %h want %h 0 100",
                         i, o.rd, o.err, o.addr, exp[i]);
            end
        end
    endtask

    task automatic test_store();
        obs_t o;
        access(1'b1, 3'b000, 32'h101, 32'h1234_5678, 32'h0, 0, 0, o);
        n_tests++;
        if (o.timed_out || o.lat != 2 || o.be !== 4'b0010 || o.wdata !== 32'h7878_7878 ||
            o.addr !== 32'h100 || o.we !== 1'b1 || o.err !== 1'b0 || o.rd !== 32'h0) begin
            n_fail++;
            $display("FAIL store_sb: lat %0d be %b wd %h addr %h we %b want 2 0010 78787878 100 1",
                     o.lat, o.be, o.wdata, o.addr, o.we);
        end
        access(1'b1, 3'b001, 32'h102, 32'h1234_5678, 32'h0, 0, 0, o);
        n_tests++;
        if (o.timed_out || o.lat != 2 || o.be !== 4'b1100 || o.wdata !== 32'h5678_5678) begin
            n_fail++;
            $display("FAIL store_sh: lat %0d be %b wd %h want 2 1100 56785678",
                     o.lat, o.be, o.wdata);
        end
        // rsp_valid is a single-cycle pulse and the unit is ready again.
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pulse: valid %b ready %b busy %b want 0 1 0",
                     rsp_valid, req_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gnt_stall();
        obs_t o;
        access(1'b0, 3'b010, 32'h0000_0A40, 32'h0, 32'hCAFE_F00D, 5, 0, o);
        n_tests++;
        if (o.timed_out || !o.saw_req || !o.stable || o.lat != 8 || o.rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL gnt_stall: lat %0d stable %b rd %h want 8 1 cafef00d",
                     o.lat, o.stable, o.rd);
        end
    endtask

    task automatic test_errors();
        logic        ws  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] adr [3] = '{32'h102, 32'h101, 32'h100};
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            access(ws[i], f3s[i], adr[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, o);
            n_tests++;
            if (o.timed_out || o.saw_req || o.lat != 1 || o.err !== 1'b1 || o.rd !== 32'h0) begin
                n_fail++;
                $display("FAIL error[%0d]: lat %0d req %b err %b rd %h want 1 0 1 0",
                         i, o.lat, o.saw_req, o.err, o.rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int stray;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, busy, rsp_valid, mem_bus.mem_req} !== 4'b1000 ||
            mem_bus.mem_addr !== 32'h0 || mem_bus.mem_be !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ready %b busy %b valid %b req %b addr %h be %b want 1 0 0 0 0 0",
                     req_ready, busy, rsp_valid, mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_be);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stray++;
            @(posedge clk); #1;
            mem_bus.mem_rvalid = 1'b0;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL late_rvalid: %0d cycles with activity want 0", stray);
        end
        access(1'b0, 3'b010, 32'h300, 32'h0, 32'h0BAD_C0DE, 0, 0, o);
        n_tests++;
        if (o.timed_out || o.lat != 3 || o.rd !== 32'h0BAD_C0DE || o.addr !== 32'h300) begin
            n_fail++;
            $display("FAIL after_reset_lw: lat %0d rd %h addr %h want 3 0badc0de 300",
                     o.lat, o.rd, o.addr);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic w, e_err;
        logic [2:0] f3;
        logic [3:0] e_be;
        logic [31:0] a, wd, rd, e_wd, e_rd;
        int g, r, e_lat;
        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom); f3 = 3'($urandom_range(0, 7));
            a = $urandom; wd = $urandom; rd = $urandom;
            g = $urandom_range(0, 3); r = $urandom_range(0, 3);
            model(w, f3, a, wd, rd, e_err, e_be, e_wd, e_rd);
            e_lat = e_err ? 1 : (w ? 2 + g : 3 + g + r);
            access(w, f3, a, wd, rd, g, r, o);
            n_tests++;
            if (o.timed_out || o.lat != e_lat || o.err !== e_err || o.rd !== e_rd ||
                o.saw_req !== !e_err || !o.stable ||
                (!e_err && (o.be !== e_be || o.addr !== {a[31:2], 2'b00} || o.we !== w)) ||
                (!e_err && w && o.wdata !== e_wd)) begin
                n_fail++;
                $display("FAIL random[%0d] w%b f3 %b a %h: lat %0d/%0d err %b/%b rd %h/%h be %b/%b wd %h/%h",
                         i, w, f3, a, o.lat, e_lat, o.err, e_err, o.rd, e_rd, o.be, e_be,
                         o.wdata, e_wd);
            end
        end
    endtask

    initial begin
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        test_reset();
        test_lw_basic();
        test_load_ext();
        test_store();
        test_gnt_stall();
        test_errors();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
